// File: rtl/spi_rx_fifo_if.sv
// spi_rx_fifo_if: SPI pins plus the receive-word stream and status bundle; SPI_RX_SOF_EN adds out_sof
interface spi_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                   spi_sck;
  logic                   spi_csn;
  logic                   spi_sdi;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] level;
  logic                   busy;
  logic                   overflow;
  logic                   overflow_clr;
`ifdef SPI_RX_SOF_EN
  logic                   out_sof;
`endif
  modport master (
    output spi_sck, spi_csn, spi_sdi, out_ready, overflow_clr,
`ifdef SPI_RX_SOF_EN
    input  out_sof,
`endif
    input  out_data, out_valid, level, busy, overflow
  );
  modport slave (
    input  spi_sck, spi_csn, spi_sdi, out_ready, overflow_clr,
`ifdef SPI_RX_SOF_EN
    output out_sof,
`endif
    output out_data, out_valid, level, busy, overflow
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: oversampling SPI slave receiver with show-ahead word FIFO; SPI_RX_SOF_EN tags first word of each frame
module spi_rx_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  spi_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
`ifdef SPI_RX_SOF_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  logic [SYNC_STAGES+1:0] r_sck;
  logic [SYNC_STAGES+1:0] r_csn;
  logic [SYNC_STAGES:0]   r_sdi;
  logic [WIDTH-2:0]       r_shift;
  logic [CW-1:0]          r_cnt;
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic [EW-1:0]          r_mem [DEPTH];
  logic [EW-1:0]          r_head;
  logic                   r_ovf;
  logic                   w_sck;
  logic                   w_sck_prev;
  logic                   w_csn;
  logic                   w_csn_prev;
  logic                   w_edge;
  logic                   w_done;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic [WIDTH-1:0]       w_word;
  logic [EW-1:0]          w_entry;
  logic [AW:0]            w_rnext;
  logic [AW:0]            w_wnext;
  // the chains are one flop longer than the synchroniser so edges compare two settled samples
  assign w_sck      = r_sck[SYNC_STAGES];
  assign w_sck_prev = r_sck[SYNC_STAGES+1];
  assign w_csn      = r_csn[SYNC_STAGES];
  assign w_csn_prev = r_csn[SYNC_STAGES+1];
  assign w_edge     = ~w_csn & ((CPOL ^ CPHA) ? (w_sck_prev & ~w_sck) : (w_sck & ~w_sck_prev));
  assign w_done     = w_edge && (r_cnt == CW'(WIDTH - 1));
  assign w_word     = {r_shift, r_sdi[SYNC_STAGES]};
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty    = r_wptr == r_rptr;
  assign w_pop      = ~w_empty & bus.out_ready;
  assign w_push     = w_done & (~w_full | w_pop);
  assign w_rnext    = r_rptr + (AW+1)'(w_pop);
  assign w_wnext    = r_wptr + (AW+1)'(w_push);
`ifdef SPI_RX_SOF_EN
  logic r_sof_arm;
  assign w_entry     = {r_sof_arm, w_word};
  assign bus.out_sof = r_head[WIDTH] & ~w_empty;
  // arm on csn fall; any completed word (kept or dropped) consumes the flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sof_arm <= 1'b0;
    else if (w_csn_prev & ~w_csn) r_sof_arm <= 1'b1;
    else if (w_done) r_sof_arm <= 1'b0;
`else
  assign w_entry = w_word;
`endif
  assign bus.out_data  = r_head[WIDTH-1:0];
  assign bus.out_valid = ~w_empty;
  assign bus.level     = r_wptr - r_rptr;
  assign bus.busy      = ~w_csn;
  assign bus.overflow  = r_ovf;
  // input synchronisers with edge-history stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sck <= {(SYNC_STAGES+2){CPOL}};
      r_csn <= '1;
      r_sdi <= '0;
    end else begin
      r_sck <= {r_sck[SYNC_STAGES:0], bus.spi_sck};
      r_csn <= {r_csn[SYNC_STAGES:0], bus.spi_csn};
      r_sdi <= {r_sdi[SYNC_STAGES-1:0], bus.spi_sdi};
    end
  // MSB-first deserialiser; csn rise drops any partial word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_csn & ~w_csn_prev) r_cnt <= '0;
    else if (w_edge) begin
      r_shift <= w_word[WIDTH-2:0];
      r_cnt   <= w_done ? '0 : r_cnt + CW'(1);
    end
  // pointers, sticky overflow and registered show-ahead head word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_head <= '0;
    end else begin
      r_wptr <= w_wnext;
      r_rptr <= w_rnext;
      r_ovf  <= (w_done & w_full & ~w_pop) | (r_ovf & ~bus.overflow_clr);
      if (w_rnext != w_wnext) r_head <= (w_rnext == r_wptr) ? w_entry : r_mem[w_rnext[AW-1:0]];
    end
  // storage array, written at the tail on every accepted word
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_entry;
endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed vector bench for spi_rx_fifo in mode 0 and mode 3
module tb_spi_rx_fifo;
  typedef struct {
    logic [7:0] data;
    logic [2:0] level;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck [2];
  logic       csn [2];
  logic       sdi [2];
  logic       rdy [2];
  logic       clr [2];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] q3 [$];
  vec_t       v3 [4];
  vec_t       v5 [4];
  logic [7:0] m3 [3];

  always #5 clk = ~clk;

  spi_rx_fifo_if #(.WIDTH(8), .DEPTH(4)) b0 ();
  spi_rx_fifo_if #(.WIDTH(8), .DEPTH(4)) b3 ();
  assign b0.spi_sck = sck[0];
  assign b0.spi_csn = csn[0];
  assign b0.spi_sdi = sdi[0];
  assign b0.out_ready = rdy[0];
  assign b0.overflow_clr = clr[0];
  assign b3.spi_sck = sck[1];
  assign b3.spi_csn = csn[1];
  assign b3.spi_sdi = sdi[1];
  assign b3.out_ready = rdy[1];
  assign b3.overflow_clr = clr[1];

  spi_rx_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  spi_rx_fifo #(.WIDTH(8), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  always @(negedge clk) if (b3.out_valid && b3.out_ready) q3.push_back(b3.out_data);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bit_out(input int m, input logic b);
    sck[m] = 1'b0;
    sdi[m] = b;
    #40;
    sck[m] = 1'b1;
  endtask

  task automatic send_bits(input int m, input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bit_out(m, v[i]);
      #40;
    end
  endtask

  task automatic frame_start(input int m);
    csn[m] = 1'b0;
    #80;
  endtask

  task automatic frame_end(input int m);
    sck[m] = (m == 1);
    #40;
    csn[m] = 1'b1;
    #80;
  endtask

  task automatic pop0();
    rdy[0] = 1'b1;
    #10;
    rdy[0] = 1'b0;
  endtask

  initial begin
    v3 = '{'{8'h01, 3'd4}, '{8'h02, 3'd3}, '{8'h03, 3'd2}, '{8'h04, 3'd1}};
    v5 = '{'{8'h12, 3'd4}, '{8'h13, 3'd3}, '{8'h14, 3'd2}, '{8'h77, 3'd1}};
    m3 = '{8'h12, 8'h34, 8'h56};
    sck[0] = 1'b0; sck[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      csn[i] = 1'b1; sdi[i] = 1'b0; clr[i] = 1'b0;
    end
    rdy[0] = 1'b0; rdy[1] = 1'b1;
    #20;
    chk("rst_valid", b0.out_valid, 0);
    chk("rst_data", b0.out_data, 0);
    chk("rst_level", b0.level, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_ovf", b0.overflow, 0);
    rst_n = 1'b1;
    #80;
    // single word, latency and pop-while-empty
    frame_start(0);
    send_bits(0, 8'hA5, 7);
    bit_out(0, 1'b1);
    #30;
    chk("lat_early", b0.out_valid, 0);
    #10;
    chk("t1_valid", b0.out_valid, 1);
    chk("t1_data", b0.out_data, 8'hA5);
    chk("t1_level", b0.level, 1);
    chk("t1_ovf", b0.overflow, 0);
    chk("t1_busy", b0.busy, 1);
    frame_end(0);
    chk("t1_idle", b0.busy, 0);
    pop0();
    chk("t1_pop_valid", b0.out_valid, 0);
    chk("t1_pop_level", b0.level, 0);
    pop0();
    chk("t1_empty_pop_level", b0.level, 0);
    chk("t1_empty_hold", b0.out_data, 8'hA5);
    // mode 3 back-to-back frame, always ready
    frame_start(1);
    send_bits(1, 8'h12, 8);
    send_bits(1, 8'h34, 8);
    send_bits(1, 8'h56, 8);
    frame_end(1);
    #100;
    chk("m3_count", q3.size(), 3);
    for (int i = 0; i < 3; i++) chk("m3_pop", (i < q3.size()) ? q3[i] : 8'hxx, m3[i]);
    chk("m3_level", b3.level, 0);
    // overflow with five words into four entries
    frame_start(0);
    for (int w = 1; w <= 5; w++) send_bits(0, 8'(w), 8);
    frame_end(0);
    #40;
    chk("t3_level", b0.level, 4);
    chk("t3_ovf", b0.overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_data", b0.out_data, v3[i].data);
      chk("t3_lvl", b0.level, v3[i].level);
      pop0();
    end
    chk("t3_drained", b0.out_valid, 0);
    chk("t3_ovf_sticky", b0.overflow, 1);
    clr[0] = 1'b1;
    #10;
    clr[0] = 1'b0;
    chk("t3_ovf_clr", b0.overflow, 0);
    // partial word discarded at frame end
    frame_start(0);
    send_bits(0, 8'hFF, 5);
    frame_end(0);
    frame_start(0);
    send_bits(0, 8'h3C, 8);
    frame_end(0);
    #40;
    chk("t4_level", b0.level, 1);
    chk("t4_data", b0.out_data, 8'h3C);
    pop0();
    chk("t4_empty", b0.level, 0);
    // push and pop in the same cycle while full
    frame_start(0);
    for (int w = 0; w < 4; w++) send_bits(0, 8'h11 + 8'(w), 8);
    send_bits(0, 8'h77, 7);
    bit_out(0, 1'b1);
    #30;
    rdy[0] = 1'b1;
    #10;
    rdy[0] = 1'b0;
    chk("t5_level", b0.level, 4);
    chk("t5_ovf", b0.overflow, 0);
    frame_end(0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_data", b0.out_data, v5[i].data);
      chk("t5_lvl", b0.level, v5[i].level);
      pop0();
    end
    chk("t5_drained", b0.level, 0);
    // asynchronous reset mid-word with two words queued
    frame_start(0);
    send_bits(0, 8'h81, 8);
    send_bits(0, 8'h42, 8);
    send_bits(0, 8'hFF, 3);
    chk("t6_pre_level", b0.level, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", b0.out_valid, 0);
    chk("t6_level", b0.level, 0);
    chk("t6_busy", b0.busy, 0);
    chk("t6_data", b0.out_data, 0);
    #9;
    csn[0] = 1'b1;
    sck[0] = 1'b0;
    #20;
    rst_n = 1'b1;
    #80;
    frame_start(0);
    send_bits(0, 8'h9E, 8);
    frame_end(0);
    #40;
    chk("t6_after_level", b0.level, 1);
    chk("t6_after_data", b0.out_data, 8'h9E);
    pop0();
`ifdef SPI_RX_SOF_EN
    frame_start(0);
    send_bits(0, 8'hC3, 8);
    send_bits(0, 8'h3C, 8);
    frame_end(0);
    #40;
    chk("sof_first", b0.out_sof, 1);
    chk("sof_first_data", b0.out_data, 8'hC3);
    pop0();
    chk("sof_second", b0.out_sof, 0);
    chk("sof_second_data", b0.out_data, 8'h3C);
    pop0();
    chk("sof_empty", b0.out_sof, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
